// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 hex keypad, debounces press and release, and
// shifts each accepted digit into a 32-bit entry register for the display driver.
module hex_keypad_entry #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clear,
    output logic [31:0] number,
    output logic        load,
    output logic        key_valid,
    output logic [3:0]  key_code
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    // Nibble {row,col} holds the legend printed on that key
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   number_q, number_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          load_q, load_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    sync_q, rs_q;
    logic [1:0]    first_low;
    logic [3:0]    code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 4'b1111;
            rs_q        <= 4'b1111;
            state_q     <= SCAN;
            col_q       <= '0;
            row_q       <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            number_q    <= '0;
            key_code_q  <= '0;
            load_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            sync_q      <= row_in;
            rs_q        <= sync_q;
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            number_q    <= number_d;
            key_code_q  <= key_code_d;
            load_q      <= load_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign first_low = !rs_q[0] ? 2'd0 : !rs_q[1] ? 2'd1 : !rs_q[2] ? 2'd2 : 2'd3;
    assign code      = KEY_MAP[{row_q, col_q, 2'b00} +: 4];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        number_d    = number_q;
        key_code_d  = key_code_q;
        load_d      = 1'b0;
        key_valid_d = 1'b0;
        unique case (state_q)
            SCAN: begin
                // Rows are only trusted at the end of the dwell, once they have settled
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs_q != 4'b1111) begin
                        state_d = DEBOUNCE;
                        row_d   = first_low;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs_q[row_q]) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ACCEPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCEPT: begin
                number_d    = {number_q[27:0], code};
                key_code_d  = code;
                key_valid_d = 1'b1;
                load_d      = 1'b1;
                cnt_d       = '0;
                state_d     = RELEASE;
            end
            RELEASE: begin
                // Any key still down restarts the quiet period, so holds never repeat
                if (rs_q != 4'b1111) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
        if (clear) begin
            number_d = '0;
            load_d   = 1'b1;
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign number    = number_q;
    assign load      = load_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Scans a 4x4 matrix hex keypad, debounces presses and shifts each accepted hex digit into a 32-bit entry register.
- Presents the register as number and load for direct connection to the seven-segment display driver's number and load inputs.
- Sits beside the display driver in the top level; it is the user-input front end of the ALU board.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven low before the scan advances (>=4)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required for press and for release (>=2)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-low reset
row_in  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
col_out  output  4  keypad column drive, active-low, exactly one bit low at all times
clear  input  1  synchronous clear of entry register, level, sampled each clk
number  output  32  entry register; newest digit in [3:0]
load  output  1  one-cycle pulse whenever number changes
key_valid  output  1  one-cycle pulse per accepted key
key_code  output  4  hex value of last accepted key, held until next accept

Behaviour:
- Reset (rst low, async):
  - col_out=4'b1110, number=0, load=0, key_valid=0, key_code=0.
  - FSM=SCAN, column index=0, all counters=0, synchronizer flops=4'b1111.
- row_in passes through a 2-flop synchronizer; all FSM decisions use the synchronized value rs.
- Key map (row r, col c -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Multiple rows low in one column: lowest row index wins.
- FSM states: SCAN, DEBOUNCE, ACCEPT, RELEASE.
- SCAN:
  - col_out = ~(1<<col). A dwell counter runs 0..SCAN_DIV-1.
  - rs is sampled only when dwell==SCAN_DIV-1, allowing settling.
  - If any rs bit is low at the sample: latch row/col, clear debounce count, go to DEBOUNCE. col_out holds.
  - Otherwise col wraps 3->0 and dwell restarts.
- DEBOUNCE:
  - col_out frozen.
  - Latched row bit low: count++. When count reaches DEBOUNCE_CYCLES-1, go to ACCEPT.
  - Latched row bit high: go back to SCAN on the same column with dwell restarted. No output change.
- ACCEPT (exactly one cycle), registered outputs on the exit edge:
  - number <= {number[27:0], code}
  - key_code <= code
  - key_valid = 1 and load = 1 in the same cycle that the new number is visible.
  - Digits shifted out of [31:28] are discarded (wrap by truncation).
  - Next state is RELEASE.
- RELEASE:
  - col_out stays frozen.
  - Requires rs==4'b1111 for DEBOUNCE_CYCLES consecutive cycles. Any low bit restarts the count.
  - Then go to SCAN, advancing to the next column.
  - Holding a key never produces a repeat.
- clear:
  - number <= 0 and load pulses for one cycle.
  - Does not affect FSM, col_out, key_code or key_valid.
  - clear held high: number stays 0, load high every cycle.
  - clear in the same cycle as ACCEPT: clear wins (number=0, load=1), but key_valid and key_code still report the key.
- load and key_valid are never high for more than one cycle per event, except under a held clear.
- Reset mid-debounce or mid-release: all state is discarded immediately and the key is not accepted.
- Press-to-load latency is 2 (sync) + up to SCAN_DIV (sample wait) + DEBOUNCE_CYCLES + 1 clk.

Test Plan:
(bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8; keypad model ties row r low when its column is low and key (r,c) is held)
- Reset then idle 100 cycles -> col_out cycles 1110,1101,1011,0111 every 4 clk; number=0; load and key_valid never high.
- Press (r1,c2) for 40 cycles, then release -> one key_valid/load pulse; key_code=6; number=0x00000006; col_out frozen at 1011 until 8 idle cycles after release.
- Bouncy press (r0,c0) toggling every 3 cycles for 30 cycles, then stable -> exactly one accept (number=0x1) after stable; no accept during bounce.
- Enter 1,2,3,4,5,6,7,8,9 -> number=0x23456789; nine load pulses; 0x1 lost off the top.
- Hold (r3,c1) for 200 cycles -> single accept, code 0; clear pulsed mid-hold -> number=0, load=1 that cycle, no new key_valid.
- clear asserted on the ACCEPT cycle of key A -> number=0, load=1, key_valid=1, key_code=A; rst low during DEBOUNCE -> no accept, col_out=1110.
